uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- UART transmitter peripheral downstream of the CPU core. It consumes bytes the CPU writes through a memory-mapped store and drives the FTDI transmit line.
- A small FIFO decouples CPU store bursts from the serial line rate.
- Frame format: 8N1, LSB first.
- Sits between the CPU's IO write strobe and the top-level ftdi_txd pin.

Parameters:
- CLKS_PER_BIT, 217, clk cycles per serial bit; legal range 2..65535.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries.

Ports:
- clk  input  1  system clock; all logic on posedge.
- resetn  input  1  synchronous active-low reset, sampled on posedge clk.
- wr_valid  input  1  CPU requests a byte write this cycle.
- wr_data  input  8  byte to transmit.
- wr_ready  output  1  FIFO not full (count < depth); combinational from count.
- tx  output  1  serial line, registered, idle high.
- busy  output  1  high when state != IDLE or the FIFO is non-empty.
- fifo_count  output  FIFO_AW+1  number of bytes queued, excluding the byte being shifted.
- overflow  output  1  sticky; set when wr_valid arrives while the FIFO is full.

Behaviour:
- Reset (resetn low at posedge):
  - tx=1, state=IDLE, FIFO pointers=0, fifo_count=0, overflow=0, baud counter=0, bit index=0.
  - Reset mid-frame aborts immediately: tx returns high on the next edge and queued bytes are discarded.
- FIFO:
  - Push when wr_valid && wr_ready.
  - Pop is internal, performed by the TX FSM.
  - Simultaneous push and pop, including when full, is legal: count is unchanged and both take effect.
  - A write while full with no pop in the same cycle is dropped and sets overflow.
  - Pointers wrap modulo depth; count is kept as a separate FIFO_AW+1-bit register.
- Baud timing:
  - The counter runs from 0 to CLKS_PER_BIT-1; each bit occupies exactly CLKS_PER_BIT cycles.
  - The counter restarts at 0 on every state entry.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_count != 0: pop the head into the shift register, go to START, tx<=0 on the same edge.
  - START: after CLKS_PER_BIT cycles, go to DATA, tx<=shift[0], bit index=0.
  - DATA: at each bit end, shift right and increment the index. After bit 7 ends, go to STOP, tx<=1.
  - STOP: one bit time. At its end, if the FIFO is non-empty, pop and go directly to START (tx<=0), giving no idle gap between frames. Otherwise go to IDLE.
- Latency: wr_valid sampled at edge N into an empty, idle block → count=1 after N → pop at N+1 → tx low from N+1.
- Frame length: 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- A write arriving during the last STOP cycle is not visible to that cycle's pop decision; it is popped the following cycle from IDLE.
- wr_ready, busy and fifo_count are valid every cycle, including during reset (all reflect reset values).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, transmitting even parity (XOR of the 8 data bits) for one bit time.
  - Frame becomes 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state exists and the frame is 8N1 as above.
- Ports are identical in both builds.

Test Plan:
- Reset then idle, CLKS_PER_BIT=4 → tx=1, busy=0, wr_ready=1, fifo_count=0, overflow=0 for 100 cycles.
- Write 0x55 at edge N → tx low on cycles N+1..N+4, then 1,0,1,0,1,0,1,0 each for 4 cycles, then high for 4 cycles; busy falls at N+41.
- Write 0xA5, 0x3C, 0xFF on consecutive cycles → three contiguous 40-cycle frames with no idle gap; fifo_count peaks at 2; byte order preserved.
- With FIFO_AW=2: write 6 bytes back-to-back → first 5 accepted (1 popped + 4 queued), 6th dropped; overflow=1 and stays 1 until reset.
- Assert resetn low mid-DATA of byte 0x0F → tx=1 the next cycle, fifo_count=0, state IDLE; a new write afterward produces a clean frame.
- UART_TX_PARITY_EN defined, write 0x07 → parity bit=1, stop bit follows, frame is 44 cycles; write 0x03 → parity bit=0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide write port into a small FIFO that drains onto an 8N1 serial line,
// LSB first, with back-to-back frames sent without an idle gap.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 217,
   parameter int unsigned FIFO_AW      = 2
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               wr_valid,
   input  logic [7:0]         wr_data,
   output logic               wr_ready,
   output logic               tx,
   output logic               busy,
   output logic [FIFO_AW:0]   fifo_count,
   output logic               overflow
);

   localparam int unsigned       DEPTH_N  = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]  DEPTH    = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [15:0]       BAUD_MAX = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_TX_PARITY_EN
      StParity,
`endif
      StStop
   } state_e;

   // FIFO storage and bookkeeping
   logic [7:0]         mem [DEPTH_N];
   logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]   count_q;
   logic               overflow_q;
   logic               full;
   logic               push;
   logic               pop;

   // Transmit FSM state
   state_e      state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;
   logic        baud_end;

   assign full     = (count_q == DEPTH);
   // A pop in the same cycle frees a slot, so a write into a full FIFO is still taken then.
   assign push     = wr_valid && (!full || pop);
   assign baud_end = (baud_q == BAUD_MAX);

   assign wr_ready   = (count_q < DEPTH);
   assign fifo_count = count_q;
   assign overflow   = overflow_q;
   assign tx         = tx_q;
   assign busy       = (state_q != StIdle) || (count_q != '0);

   // FIFO data array; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

   // FIFO pointers, occupancy count and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
         if (wr_valid && full && !pop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Transmit FSM state register; tx is registered so the line never glitches.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   // Next-state logic: bit timing, shifting and FIFO pop decisions.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + 16'd1;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            tx_d   = 1'b1;
            baud_d = '0;
            if (count_q != '0) begin
               pop     = 1'b1;
               shift_d = mem[rd_ptr_q];
               state_d = StStart;
               tx_d    = 1'b0;
            end
         end
         StStart: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = shift_q[0];
               state_d = StData;
            end
         end
         StData: begin
            if (baud_end) begin
               baud_d = '0;
               // Rotate rather than shift so the byte is intact for the parity bit.
               shift_d = {shift_q[0], shift_q[7:1]};
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = ^shift_q;
                  state_d = StParity;
`else
                  tx_d    = 1'b1;
                  state_d = StStop;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = shift_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (baud_end) begin
               baud_d  = '0;
               tx_d    = 1'b1;
               state_d = StStop;
            end
         end
`endif
         StStop: begin
            if (baud_end) begin
               baud_d = '0;
               if (count_q != '0) begin
                  pop     = 1'b1;
                  shift_d = mem[rd_ptr_q];
                  state_d = StStart;
                  tx_d    = 1'b0;
               end else begin
                  tx_d    = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         default: begin
            baud_d  = '0;
            tx_d    = 1'b1;
            state_d = StIdle;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed writes feed a scoreboard queue; a line monitor decodes
// each frame from tx and compares it against the queued byte.
module tb_uart_tx_fifo;

   localparam int unsigned CPB = 4;
   localparam int unsigned AW  = 2;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * CPB;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          wr_valid = 1'b0;
   logic [7:0]    wr_data = 8'h00;
   logic          wr_ready;
   logic          tx;
   logic          busy;
   logic [AW:0]   fifo_count;
   logic          overflow;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   bit          mon_en = 1'b0;
   logic [7:0]  exp_q[$];
   int          starts[$];
   int          n_pushed = 0;
   int          n_frames = 0;

   uart_tx_fifo #(
      .CLKS_PER_BIT (CPB),
      .FIFO_AW      (AW)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [10:0] frame_word(input logic [7:0] b);
      logic [10:0] w;
      w = '0;
      w[8:1] = b;
`ifdef UART_TX_PARITY_EN
      w[9]  = ^b;
      w[10] = 1'b1;
`else
      w[9]  = 1'b1;
`endif
      return w;
   endfunction

   // Single write; the accepting edge is the posedge between the two negedges.
   task automatic wr(input logic [7:0] b, input bit expect_it);
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = b;
      if (expect_it) begin
         exp_q.push_back(b);
         n_pushed++;
      end
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   // Line monitor: on a start bit, sample every cycle of every bit and compare the frame.
   initial begin
      logic [7:0]  b;
      logic [10:0] exp_w;
      logic [10:0] obs_w;
      bit          stable;
      bit          have_exp;
      forever begin
         @(negedge clk);
         if (mon_en && resetn && tx === 1'b0) begin
            starts.push_back(cyc);
            n_frames++;
            have_exp = (exp_q.size() != 0);
            b = have_exp ? exp_q.pop_front() : 8'h00;
            exp_w  = frame_word(b);
            obs_w  = '0;
            stable = 1'b1;
            for (int bi = 0; bi < NB; bi++) begin
               for (int c = 0; c < int'(CPB); c++) begin
                  if (bi != 0 || c != 0) @(negedge clk);
                  if (c == 0) obs_w[bi] = tx;
                  else if (tx !== obs_w[bi]) stable = 1'b0;
               end
            end
            check("frame_present", 32'(have_exp), 32'd1);
            check("frame_bits", 32'(obs_w), 32'(exp_w));
            check("frame_bit_width", 32'(stable), 32'd1);
         end
      end
   end

   // Hard time limit so a stuck run still ends.
   initial begin
      #400000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int          n0;
      int          bad;
      logic [AW:0] peak;
      logic [7:0]  burst3 [3];
      logic [7:0]  burst6 [6];
      burst3 = '{8'hA5, 8'h3C, 8'hFF};
      burst6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

      // Reset values are visible while reset is held.
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wr_ready", 32'(wr_ready), 32'd1);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      resetn = 1'b1;
      mon_en = 1'b1;

      // Idle for 100 cycles.
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b1 || fifo_count !== '0 ||
             overflow !== 1'b0) bad++;
      end
      check("idle_stable_bad_cycles", 32'(bad), 32'd0);

      // Single byte: latency and busy fall time.
      wr(8'h55, 1'b1);
      check("single_count_after_write", 32'(fifo_count), 32'd1);
      check("single_busy_after_write", 32'(busy), 32'd1);
      @(negedge clk);
      check("single_tx_start", 32'(tx), 32'd0);
      check("single_count_after_pop", 32'(fifo_count), 32'd0);
      repeat (FRAME - 1) @(negedge clk);
      check("single_busy_last_stop", 32'(busy), 32'd1);
      @(negedge clk);
      check("single_busy_fall", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);

      // Three bytes on consecutive cycles: contiguous frames, order preserved.
      starts.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         wr_valid = 1'b1;
         wr_data  = burst3[i];
         exp_q.push_back(burst3[i]);
         n_pushed++;
      end
      @(negedge clk);
      wr_valid = 1'b0;
      peak = fifo_count;
      repeat (3 * FRAME + 4) begin
         @(negedge clk);
         if (fifo_count > peak) peak = fifo_count;
      end
      check("burst_peak_count", 32'(peak), 32'd2);
      check("burst_frames", 32'(starts.size()), 32'd3);
      if (starts.size() == 3) begin
         check("burst_gap_01", 32'(starts[1] - starts[0]), 32'(FRAME));
         check("burst_gap_12", 32'(starts[2] - starts[1]), 32'(FRAME));
      end
      repeat (3) @(negedge clk);

      // Six bytes back-to-back: five accepted, the sixth dropped.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         wr_valid = 1'b1;
         wr_data  = burst6[i];
         if (i < 5) begin
            exp_q.push_back(burst6[i]);
            n_pushed++;
         end
      end
      @(negedge clk);
      wr_valid = 1'b0;
      check("ovf_count_full", 32'(fifo_count), 32'd4);
      check("ovf_wr_ready", 32'(wr_ready), 32'd0);
      check("ovf_flag_set", 32'(overflow), 32'd1);
      repeat (5 * FRAME + 5) @(negedge clk);
      check("ovf_flag_sticky", 32'(overflow), 32'd1);
      check("ovf_drained_busy", 32'(busy), 32'd0);
      check("ovf_queue_empty", 32'(exp_q.size()), 32'd0);

      // Reset mid-DATA of 0x0F with 0x11 queued behind it.
      mon_en = 1'b0;
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = 8'h0F;
      @(negedge clk);
      wr_data  = 8'h11;
      @(negedge clk);
      wr_valid = 1'b0;
      repeat (9) @(negedge clk);
      check("rstmid_queued", 32'(fifo_count), 32'd1);
      resetn = 1'b0;
      @(negedge clk);
      check("rstmid_tx", 32'(tx), 32'd1);
      check("rstmid_count", 32'(fifo_count), 32'd0);
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_overflow", 32'(overflow), 32'd0);
      resetn = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
      wr(8'h96, 1'b1);
      repeat (FRAME + 3) @(negedge clk);
      check("rstmid_after_idle", 32'(busy), 32'd0);

`ifdef UART_TX_PARITY_EN
      // Parity: 0x07 has odd weight (parity 1), 0x03 even weight (parity 0).
      wr(8'h07, 1'b1);
      n0 = cyc;
      @(negedge clk);
      check("par_tx_start", 32'(tx), 32'd0);
      repeat (FRAME - 1) @(negedge clk);
      check("par_busy_last_stop", 32'(busy), 32'd1);
      @(negedge clk);
      check("par_frame_len", 32'(busy), 32'd0);
      wr(8'h03, 1'b1);
      repeat (FRAME + 3) @(negedge clk);
`endif

      // Drain whatever remains, bounded.
      n0 = 0;
      while ((exp_q.size() != 0 || busy) && n0 < 2000) begin
         @(negedge clk);
         n0++;
      end
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      check("final_frame_count", 32'(n_frames), 32'(n_pushed));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
